// File: rtl/wide_dff.sv
// wide_dff: WIDTH-bit D register with load enable and asynchronous active-low reset.
// Optional even-parity output q_par is built when WIDE_DFF_PARITY_EN is defined.
module wide_dff #(
    parameter int               WIDTH     = 24,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
`ifdef WIDE_DFF_PARITY_EN
    ,
    output logic             q_par
`endif
);
    always_ff @(posedge clk or negedge reset)
        if (!reset) q <= RESET_VAL;
        else if (en) q <= d;
`ifdef WIDE_DFF_PARITY_EN
    // Parity is registered alongside q so it tracks q without a reduction on the output path
    always_ff @(posedge clk or negedge reset)
        if (!reset) q_par <= ^RESET_VAL;
        else if (en) q_par <= ^d;
`endif
endmodule

// File: tb/tb_wide_dff.sv
// tb_wide_dff: vector table, reset corners, randomized model check and a 7-stage chain for wide_dff.
module tb_wide_dff;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic [23:0] d = '0;
    logic [23:0] q;
    logic        cen = 1'b0;
    logic        creset = 1'b0;
    logic [23:0] cd = '0;
    logic [23:0] cs [8];
    int checks = 0;
    int errors = 0;
    logic [23:0] hist [$];
    logic [23:0] q_m;
`ifdef WIDE_DFF_PARITY_EN
    logic q_par;
    logic cp [7];
`endif
    always #5 clk = ~clk;
    wide_dff #(.WIDTH(24), .RESET_VAL(24'h0)) dut (
        .clk(clk), .reset(reset), .en(en), .d(d), .q(q)
`ifdef WIDE_DFF_PARITY_EN
        , .q_par(q_par)
`endif
    );
    assign cs[0] = cd;
    for (genvar i = 0; i < 7; i++) begin : g_chain
        wide_dff #(.WIDTH(24), .RESET_VAL(24'h0)) stage (
            .clk(clk), .reset(creset), .en(cen), .d(cs[i]), .q(cs[i+1])
`ifdef WIDE_DFF_PARITY_EN
            , .q_par(cp[i])
`endif
        );
    end
    typedef struct {
        logic        rst_n;
        logic        en;
        logic [23:0] d;
        logic [23:0] exp;
    } vec_t;
    vec_t vecs [16];
    task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic chk_q(input string nm, input logic [23:0] exp);
        chk(nm, q, exp);
`ifdef WIDE_DFF_PARITY_EN
        chk({nm, "_par"}, {23'b0, q_par}, {23'b0, ^exp});
`endif
    endtask
    task automatic chain_step(input logic e, input logic [23:0] v, input string nm);
        @(negedge clk);
        cen = e;
        cd = v;
        @(posedge clk);
        if (e) hist.push_front(v);
        #1;
        for (int k = 0; k < 7; k++)
            chk($sformatf("%s_stage%0d", nm, k), cs[k+1], hist.size() > k ? hist[k] : 24'h0);
    endtask
    initial begin
        vecs[0]  = '{1'b1, 1'b1, 24'd64,     24'd64};
        vecs[1]  = '{1'b1, 1'b1, 24'hF00001, 24'hF00001};
        vecs[2]  = '{1'b1, 1'b1, 24'd64,     24'd64};
        vecs[3]  = '{1'b1, 1'b0, 24'd32,     24'd64};
        vecs[4]  = '{1'b1, 1'b0, 24'd32,     24'd64};
        vecs[5]  = '{1'b1, 1'b0, 24'd32,     24'd64};
        vecs[6]  = '{1'b1, 1'b1, 24'd32,     24'd32};
        vecs[7]  = '{1'b1, 1'b1, 24'h800000, 24'h800000};
        vecs[8]  = '{1'b1, 1'b1, 24'h7FFFFF, 24'h7FFFFF};
        vecs[9]  = '{1'b1, 1'b1, 24'h000000, 24'h000000};
        vecs[10] = '{1'b1, 1'b1, 24'h000007, 24'h000007};
        vecs[11] = '{1'b1, 1'b1, 24'h000003, 24'h000003};
        vecs[12] = '{1'b1, 1'b0, 24'hFFFFFF, 24'h000003};
        vecs[13] = '{1'b0, 1'b1, 24'hFFFFFF, 24'h000000};
        vecs[14] = '{1'b1, 1'b0, 24'h000005, 24'h000000};
        vecs[15] = '{1'b1, 1'b1, 24'h000005, 24'h000005};
        #1;
        chk_q("reset_initial", 24'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_q("release_no_change", 24'h0);
        @(posedge clk);
        #1;
        chk_q("release_en0_hold", 24'h0);
        @(negedge clk);
        en = 1'b1;
        d = 24'h000040;
        @(posedge clk);
        #1;
        chk_q("preload_40", 24'h000040);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk_q("async_reset_midcycle", 24'h0);
        d = 24'hFFFFFF;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk_q("reset_dominates_en", 24'h0);
        end
        @(negedge clk);
        reset = 1'b1;
        en = 1'b0;
        #1;
        chk_q("release_again", 24'h0);
        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst_n;
            en = vecs[i].en;
            d = vecs[i].d;
            @(posedge clk);
            #1;
            chk_q($sformatf("vec%0d", i), vecs[i].exp);
        end
        q_m = q;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 15) != 0);
            en = $urandom_range(0, 1) == 1;
            d = 24'($urandom);
            if (!reset) q_m = 24'h0;
            #1;
            chk_q("rand_between_edges", q_m);
            @(posedge clk);
            if (reset && en) q_m = d;
            #1;
            chk_q("rand_after_edge", q_m);
        end
        @(negedge clk);
        creset = 1'b1;
        for (int i = 0; i < 10; i++) chain_step(1'b1, 24'd64, "chain_fill64");
        for (int i = 0; i < 3; i++) chain_step(1'b1, 24'd32, "chain_shift32");
        for (int i = 0; i < 3; i++) chain_step(1'b0, 24'd99, "chain_frozen");
        for (int i = 0; i < 5; i++) chain_step(1'b1, 24'd32, "chain_resume");
        for (int i = 0; i < 60; i++) chain_step($urandom_range(0, 3) != 0, 24'($urandom), "chain_rand");
        @(negedge clk);
        creset = 1'b0;
        hist.delete();
        #1;
        for (int k = 0; k < 7; k++) chk($sformatf("chain_reset_stage%0d", k), cs[k+1], 24'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
